// File: rtl/page_stream_qout_pkg.sv
// Shared definitions for the page output stream queue: token layout and pointer sizing.
package page_stream_qout_pkg;

   // Token is {data, eos}; eos sits in bit 0, data above it
   localparam int unsigned EOS_BIT = 0;

   // Ceiling log2, used to size pointers from the slot count
   function automatic int unsigned log2Ceil(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << result) < 64'(value)) result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/page_stream_qout_regfile.sv
// Token storage: DEPTH x TW register array, one write port, one asynchronous read port.
module page_stream_qout_regfile
   import page_stream_qout_pkg::*;
#(
   parameter int unsigned TW    = 17,
   parameter int unsigned DEPTH = 4
)(
   input  logic                       clock,
   input  logic                       wrEn,
   input  logic [log2Ceil(DEPTH)-1:0] wrAddr,
   input  logic [TW-1:0]              wrData,
   input  logic [log2Ceil(DEPTH)-1:0] rdAddr,
   output logic [TW-1:0]              rdData_c
);

   logic [TW-1:0] mem [DEPTH];

   // Storage carries no reset; validity is tracked by the owner's count
   always_ff @(posedge clock) begin
      if (wrEn) mem[wrAddr] <= wrData;
   end

   assign rdData_c = mem[rdAddr];

endmodule

// File: rtl/page_stream_qout.sv
// Output-side stream queue of a page: buffers {data, eos} tokens from the page body
// and presents them downstream with registered, early-raised back-pressure.
// Optional feature: define PAGE_QOUT_OVF_FLAG_EN to add the sticky outs_ovf flag.
module page_stream_qout
   import page_stream_qout_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SLACK = 1
)(
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] outs_qin_d,
   input  logic         outs_qin_e,
   input  logic         outs_qin_v,
   output logic         outs_qin_b,
   output logic [W-1:0] outs_qout_d,
   output logic         outs_qout_e,
   output logic         outs_qout_v,
   input  logic         outs_qout_b
`ifdef PAGE_QOUT_OVF_FLAG_EN
   ,
   output logic         outs_ovf
`endif
);

   localparam int unsigned AW = log2Ceil(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = W + 1;

   logic [AW-1:0] rdPtr;
   logic [AW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic [CW-1:0] countNext;
   logic          full;
   logic          push;
   logic          pop;
   logic          qinB;
   logic [TW-1:0] wrToken;
   logic [TW-1:0] rdToken;

   // Handshake decode; a full queue still accepts when the head leaves this cycle
   always_comb begin
      full      = (count == CW'(DEPTH));
      pop       = (count != '0) & ~outs_qout_b;
      push      = outs_qin_v & (~full | pop);
      countNext = count + CW'(push) - CW'(pop);
      wrToken   = {outs_qin_d, outs_qin_e};
   end

   page_stream_qout_regfile #(
      .TW    (TW),
      .DEPTH (DEPTH)
   ) regfile (
      .clock    (clock),
      .wrEn     (push & reset),
      .wrAddr   (wrPtr),
      .wrData   (wrToken),
      .rdAddr   (rdPtr),
      .rdData_c (rdToken)
   );

   // Pointers, occupancy and back-pressure that anticipates the next occupancy
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         qinB  <= 1'b1;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         count <= countNext;
         qinB  <= (countNext >= CW'(DEPTH - SLACK));
      end
   end

   // Head token is forced to zero whenever the queue is empty
   always_comb begin
      outs_qout_v = (count != '0);
      outs_qout_d = outs_qout_v ? rdToken[TW-1:1] : '0;
      outs_qout_e = outs_qout_v ? rdToken[EOS_BIT] : 1'b0;
      outs_qin_b  = qinB;
   end

`ifdef PAGE_QOUT_OVF_FLAG_EN
   logic drop;
   logic ovfFlag;

   assign drop     = outs_qin_v & ~push;
   assign outs_ovf = ovfFlag;

   // Sticky record of any token lost to a full queue; complains once
   always_ff @(posedge clock) begin
      if (!reset) begin
         ovfFlag <= 1'b0;
      end else begin
         if (drop) ovfFlag <= 1'b1;
         assert (!(drop && !ovfFlag))
            else $error("page_stream_qout: token dropped, queue full");
      end
   end
`endif

endmodule

// File: tb/tb_page_stream_qout.sv
// Self-checking bench for page_stream_qout (W=16, DEPTH=4, SLACK=1).
module tb_page_stream_qout;

   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SLACK = 1;

   logic         clock;
   logic         reset;
   logic [W-1:0] qinD;
   logic         qinE;
   logic         qinV;
   logic         qinB;
   logic [W-1:0] qoutD;
   logic         qoutE;
   logic         qoutV;
   logic         qoutB;
`ifdef PAGE_QOUT_OVF_FLAG_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   // Behavioural reference: a plain queue of {data, eos} tokens
   logic [W:0] modelQ [$];
   bit         modelQinB = 1'b1;
   bit         modelOvf  = 1'b0;

   typedef struct {
      bit         rst;
      bit         v;
      logic [W-1:0] d;
      bit         e;
      bit         b;
      bit         expV;
      logic [W-1:0] expD;
      bit         expE;
      bit         expQinB;
   } vec_t;

   vec_t tbl [12];

   page_stream_qout #(
      .W     (W),
      .DEPTH (DEPTH),
      .SLACK (SLACK)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .outs_qin_d  (qinD),
      .outs_qin_e  (qinE),
      .outs_qin_v  (qinV),
      .outs_qin_b  (qinB),
      .outs_qout_d (qoutD),
      .outs_qout_e (qoutE),
      .outs_qout_v (qoutV),
      .outs_qout_b (qoutB)
`ifdef PAGE_QOUT_OVF_FLAG_EN
      ,
      .outs_ovf    (ovf)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Queue-level reference update for one rising edge
   task automatic modelEdge(input bit rst, input bit v, input logic [W-1:0] d,
                            input bit e, input bit b);
      bit popOk;
      bit pushOk;
      if (!rst) begin
         modelQ.delete();
         modelQinB = 1'b1;
         modelOvf  = 1'b0;
      end else begin
         popOk  = (modelQ.size() != 0) && !b;
         pushOk = v && ((modelQ.size() < DEPTH) || popOk);
         if (popOk)  void'(modelQ.pop_front());
         if (pushOk) modelQ.push_back({d, e});
         if (v && !pushOk) modelOvf = 1'b1;
         modelQinB = (modelQ.size() >= DEPTH - SLACK);
      end
   endtask

   // Drive inputs, take one edge, settle past it
   task automatic cycle(input bit rst, input bit v, input logic [W-1:0] d,
                        input bit e, input bit b);
      reset = rst;
      qinV  = v;
      qinD  = d;
      qinE  = e;
      qoutB = b;
      @(posedge clock);
      modelEdge(rst, v, d, e, b);
      #1;
   endtask

   task automatic checkModel(input string tag);
      logic [W:0] head;
      head = (modelQ.size() != 0) ? modelQ[0] : '0;
      check({tag, "_v"}, 32'(qoutV), 32'(modelQ.size() != 0));
      check({tag, "_d"}, 32'(qoutD), 32'(head[W:1]));
      check({tag, "_e"}, 32'(qoutE), 32'(head[0]));
      check({tag, "_qinb"}, 32'(qinB), 32'(modelQinB));
`ifdef PAGE_QOUT_OVF_FLAG_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(modelOvf));
`endif
   endtask

   initial begin
      reset = 1'b0; qinV = 1'b0; qinD = '0; qinE = 1'b0; qoutB = 1'b0;

      // Reset with valid held high, release, then stall fill and drain
      tbl[0]  = '{0, 1, 16'h0055, 0, 0,  0, 16'h0000, 0, 1};
      tbl[1]  = '{0, 1, 16'h0055, 0, 0,  0, 16'h0000, 0, 1};
      tbl[2]  = '{0, 1, 16'h0055, 0, 0,  0, 16'h0000, 0, 1};
      tbl[3]  = '{1, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0};
      tbl[4]  = '{1, 1, 16'h0001, 0, 1,  1, 16'h0001, 0, 0};
      tbl[5]  = '{1, 1, 16'h0002, 0, 1,  1, 16'h0001, 0, 0};
      tbl[6]  = '{1, 1, 16'h0003, 0, 1,  1, 16'h0001, 0, 1};
      tbl[7]  = '{1, 1, 16'h0004, 0, 1,  1, 16'h0001, 0, 1};
      tbl[8]  = '{1, 0, 16'h0000, 0, 0,  1, 16'h0002, 0, 1};
      tbl[9]  = '{1, 0, 16'h0000, 0, 0,  1, 16'h0003, 0, 0};
      tbl[10] = '{1, 0, 16'h0000, 0, 0,  1, 16'h0004, 0, 0};
      tbl[11] = '{1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0};

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].b);
         check($sformatf("tbl%0d_v", i), 32'(qoutV), 32'(tbl[i].expV));
         check($sformatf("tbl%0d_d", i), 32'(qoutD), 32'(tbl[i].expD));
         check($sformatf("tbl%0d_e", i), 32'(qoutE), 32'(tbl[i].expE));
         check($sformatf("tbl%0d_qinb", i), 32'(qinB), 32'(tbl[i].expQinB));
      end

      // Streaming: one-cycle latency, back-pressure never raised
      for (int i = 0; i < 16; i++) begin
         cycle(1, 1, 16'(16'h00A0 + i), 0, 0);
         check($sformatf("stream%0d_d", i), 32'(qoutD), 32'(16'h00A0 + i));
         check($sformatf("stream%0d_qinb", i), 32'(qinB), 32'd0);
         checkModel($sformatf("stream%0d", i));
      end
      cycle(1, 0, '0, 0, 0);
      checkModel("stream_end");

      // EOS forwarded opaquely, cleared once empty
      cycle(1, 1, 16'h1234, 0, 0);
      check("eos0_e", 32'(qoutE), 32'd0);
      cycle(1, 1, 16'h0000, 1, 0);
      check("eos1_d", 32'(qoutD), 32'h0);
      check("eos1_e", 32'(qoutE), 32'd1);
      cycle(1, 0, '0, 0, 0);
      check("eos_empty_e", 32'(qoutE), 32'd0);
      checkModel("eos_end");

      // Full queue: simultaneous push and pop keeps occupancy, no drop
      for (int i = 0; i < 4; i++) cycle(1, 1, 16'(16'h0010 + i), 0, 1);
      checkModel("full_fill");
      cycle(1, 1, 16'h0077, 0, 0);
      check("full_pp_head", 32'(qoutD), 32'h0011);
      check("full_pp_qinb", 32'(qinB), 32'd1);
      checkModel("full_pp");
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, '0, 0, 0);
         checkModel($sformatf("full_drain%0d", i));
      end

      // Overflow: token dropped, queue contents intact
      for (int i = 0; i < 4; i++) cycle(1, 1, 16'(16'h0020 + i), 0, 1);
      cycle(1, 1, 16'hDEAD, 0, 1);
      check("ovf_head", 32'(qoutD), 32'h0020);
`ifdef PAGE_QOUT_OVF_FLAG_EN
      check("ovf_flag", 32'(ovf), 32'd1);
`endif
      checkModel("ovf");
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, '0, 0, 0);
         check($sformatf("ovf_drain%0d_notdead", i), 32'(qoutD == 16'hDEAD), 32'd0);
         checkModel($sformatf("ovf_drain%0d", i));
      end

      // Randomized traffic with occasional overflow attempts and resets
      for (int i = 0; i < 400; i++) begin
         bit rst;
         bit v;
         bit b;
         rst = ($urandom_range(0, 63) != 0);
         v   = ($urandom_range(0, 3) != 0) && (!qinB || ($urandom_range(0, 7) == 0));
         b   = ($urandom_range(0, 2) == 0);
         cycle(rst, v, 16'($urandom), 1'($urandom), b);
         checkModel($sformatf("rand%0d", i));
      end

      // Final reset clears everything, including the sticky flag
      cycle(0, 1, 16'h5A5A, 1, 0);
      checkModel("final_rst");
      cycle(1, 0, '0, 0, 0);
      checkModel("final_release");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
